// File: rtl/conv_top_module.sv
// Fully-connected layer engine: eight signed Q-format dot products of one input vector against eight
// weight vectors, results saturated and written to the output RAM. Optional feature macro: RELU_EN.
module conv_top_module #(
  parameter int VEC_LEN   = 64,
  parameter int FRAC_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        xxx__dut__go,
  output logic        dut__xxx__finish,
  output logic [9:0]  dut__bvm__address,
  output logic        dut__bvm__enable,
  output logic        dut__bvm__write,
  output logic [15:0] dut__bvm__data,
  input  logic [15:0] bvm__dut__data,
  output logic [8:0]  dut__dim__address,
  output logic        dut__dim__enable,
  output logic        dut__dim__write,
  output logic [15:0] dut__dim__data,
  input  logic [15:0] dim__dut__data,
  output logic [2:0]  dut__dom__address,
  output logic [15:0] dut__dom__data,
  output logic        dut__dom__enable,
  output logic        dut__dom__write
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int         NUM_RD  = 8 * VEC_LEN;
  localparam logic [9:0] LAST_RD = 10'(NUM_RD - 1);

  state_t             state_q, state_d;
  logic [9:0]         cnt_q, cnt_d;
  logic [2:0]         wr_idx_q, wr_idx_d;
  logic               rd_valid_q, rd_valid_d;
  logic [2:0]         rd_filt_q, rd_filt_d;
  logic               rd_last_q, rd_last_d;
  logic [15:0]        x_hold_q, x_hold_d;
  logic signed [39:0] w_q [8];
  logic signed [39:0] w_d [8];

  logic [15:0]        x_cur;
  logic signed [31:0] prod;
  logic signed [39:0] w_sel;
  logic signed [39:0] shifted;
  logic [15:0]        sat_res;
  logic [15:0]        result;

  // Filter 0 of each element sees the input word straight off the RAM; filters 1..7 use the held copy.
  assign x_cur   = (rd_filt_q == 3'd0) ? dim__dut__data : x_hold_q;
  assign prod    = $signed(x_cur) * $signed(bvm__dut__data);
  assign w_sel   = w_q[wr_idx_q];
  assign shifted = w_sel >>> FRAC_BITS;

  always_comb begin
    sat_res = shifted[15:0];
    if (shifted > 40'sd32767) begin
      sat_res = 16'h7FFF;
    end else if (shifted < -40'sd32768) begin
      sat_res = 16'h8000;
    end
`ifdef RELU_EN
    result = sat_res[15] ? 16'h0000 : sat_res;
`else
    result = sat_res;
`endif
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_idx_d   = wr_idx_q;
    rd_valid_d = 1'b0;
    rd_filt_d  = cnt_q[2:0];
    rd_last_d  = 1'b0;
    x_hold_d   = x_hold_q;
    w_d        = w_q;

    dut__xxx__finish  = 1'b0;
    dut__bvm__address = 10'd0;
    dut__bvm__enable  = 1'b0;
    dut__bvm__write   = 1'b0;
    dut__bvm__data    = 16'd0;
    dut__dim__address = 9'd0;
    dut__dim__enable  = 1'b0;
    dut__dim__write   = 1'b0;
    dut__dim__data    = 16'd0;
    dut__dom__address = 3'd0;
    dut__dom__data    = 16'd0;
    dut__dom__enable  = 1'b0;
    dut__dom__write   = 1'b0;

    // MAC beat for the read issued one cycle earlier
    if (rd_valid_q) begin
      if (rd_filt_q == 3'd0) begin
        x_hold_d = dim__dut__data;
      end
      w_d[rd_filt_q] = w_q[rd_filt_q] + $signed({{8{prod[31]}}, prod});
    end

    case (state_q)
      S_IDLE: begin
        if (xxx__dut__go) begin
          state_d = S_READ;
          cnt_d   = 10'd0;
          for (int f = 0; f < 8; f++) begin
            w_d[f] = '0;
          end
        end
      end
      S_READ: begin
        dut__bvm__enable  = 1'b1;
        dut__bvm__address = cnt_q;
        dut__dim__enable  = (cnt_q[2:0] == 3'd0);
        dut__dim__address = {2'b00, cnt_q[9:3]};
        rd_valid_d        = 1'b1;
        rd_last_d         = (cnt_q == LAST_RD);
        if (cnt_q == LAST_RD) begin
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      S_DRAIN: begin
        // The last beat accumulates on this edge, so results are stable from the next cycle.
        if (rd_last_q) begin
          state_d  = S_WRITE;
          wr_idx_d = 3'd0;
        end
      end
      S_WRITE: begin
        dut__dom__enable  = 1'b1;
        dut__dom__write   = 1'b1;
        dut__dom__address = wr_idx_q;
        dut__dom__data    = result;
        wr_idx_d          = wr_idx_q + 3'd1;
        if (wr_idx_q == 3'd7) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        dut__xxx__finish = 1'b1;
        state_d          = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 10'd0;
      wr_idx_q   <= 3'd0;
      rd_valid_q <= 1'b0;
      rd_filt_q  <= 3'd0;
      rd_last_q  <= 1'b0;
      x_hold_q   <= 16'd0;
      for (int f = 0; f < 8; f++) begin
        w_q[f] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_idx_q   <= wr_idx_d;
      rd_valid_q <= rd_valid_d;
      rd_filt_q  <= rd_filt_d;
      rd_last_q  <= rd_last_d;
      x_hold_q   <= x_hold_d;
      for (int f = 0; f < 8; f++) begin
        w_q[f] <= w_d[f];
      end
    end
  end

endmodule

// File: tb/tb_conv_top_module.sv
// Directed bench for conv_top_module: RAM models, a bus monitor and a linear sequence of runs
// with hand-computed results.
module tb_conv_top_module;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic        finish;
  logic [9:0]  bvm_addr;
  logic        bvm_en, bvm_wr;
  logic [15:0] bvm_wdata;
  logic [15:0] bvm_rdata = 16'd0;
  logic [8:0]  dim_addr;
  logic        dim_en, dim_wr;
  logic [15:0] dim_wdata;
  logic [15:0] dim_rdata = 16'd0;
  logic [2:0]  dom_addr;
  logic [15:0] dom_data;
  logic        dom_en, dom_wr;

  logic [15:0] bvm_mem [1024];
  logic [15:0] dim_mem [512];
  logic [15:0] out_mem [8];
  logic [15:0] exp_out [8];

  int checks = 0;
  int failures = 0;
  int wr_total = 0;
  int fin_total = 0;
  int rd_total = 0;
  int seq_err = 0;
  int tie_err = 0;
  int exp_baddr = 0;

  conv_top_module dut (
    .clk               (clk),
    .reset             (reset),
    .xxx__dut__go      (go),
    .dut__xxx__finish  (finish),
    .dut__bvm__address (bvm_addr),
    .dut__bvm__enable  (bvm_en),
    .dut__bvm__write   (bvm_wr),
    .dut__bvm__data    (bvm_wdata),
    .bvm__dut__data    (bvm_rdata),
    .dut__dim__address (dim_addr),
    .dut__dim__enable  (dim_en),
    .dut__dim__write   (dim_wr),
    .dut__dim__data    (dim_wdata),
    .dim__dut__data    (dim_rdata),
    .dut__dom__address (dom_addr),
    .dut__dom__data    (dom_data),
    .dut__dom__enable  (dom_en),
    .dut__dom__write   (dom_wr)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Synchronous single-port RAM models, one-cycle read latency
  always @(posedge clk) begin
    if (bvm_en) bvm_rdata <= bvm_mem[bvm_addr];
    if (dim_en) dim_rdata <= dim_mem[dim_addr];
  end

  // Bus monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (bvm_wr !== 1'b0 || dim_wr !== 1'b0 || bvm_wdata !== 16'd0 || dim_wdata !== 16'd0) tie_err++;
    if (bvm_en === 1'b1) begin
      if (int'(bvm_addr) != exp_baddr) seq_err++;
      exp_baddr++;
      rd_total++;
    end
    if (dim_en === 1'b1) begin
      if (bvm_en !== 1'b1 || bvm_addr[2:0] !== 3'd0 || dim_addr !== {2'b00, bvm_addr[9:3]}) seq_err++;
    end
    if (dom_en === 1'b1 && dom_wr === 1'b1) begin
      out_mem[dom_addr] = dom_data;
      wr_total++;
    end else if (dom_en !== 1'b0 || dom_wr !== 1'b0) begin
      seq_err++;
    end
    if (finish === 1'b1) fin_total++;
    if (reset === 1'b1 || finish === 1'b1) exp_baddr = 0;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: go for go_cycles, optional re-pulse during READ, then wait (bounded) for finish.
  task automatic do_run(input string name, input int go_cycles, input int repulse_at);
    int wr0, fin0, rd0, lat;
    wr0 = wr_total;
    fin0 = fin_total;
    rd0 = rd_total;
    lat = 0;
    go = 1'b1;
    repeat (go_cycles) begin
      tick();
      lat++;
    end
    go = 1'b0;
    while (finish !== 1'b1 && lat < 700) begin
      tick();
      lat++;
      go = (lat == repulse_at) ? 1'b1 : 1'b0;
    end
    go = 1'b0;
    check({name, "_finish_seen"}, {31'd0, finish}, 32'd1);
    check({name, "_latency_ok"}, {31'd0, (lat <= 528)}, 32'd1);
    repeat (5) tick();
    check({name, "_finish_pulses"}, fin_total - fin0, 32'd1);
    check({name, "_dom_writes"}, wr_total - wr0, 32'd8);
    check({name, "_bvm_reads"}, rd_total - rd0, 32'd512);
    for (int f = 0; f < 8; f++) begin
      check($sformatf("%s_out%0d", name, f), {16'd0, out_mem[f]}, {16'd0, exp_out[f]});
    end
  endtask

  task automatic fill_uniform(input logic [15:0] x, input logic [15:0] wt);
    for (int i = 0; i < 512; i++) dim_mem[i] = x;
    for (int i = 0; i < 1024; i++) bvm_mem[i] = wt;
  endtask

  initial begin
    int wr0, fin0, rd0;
    for (int f = 0; f < 8; f++) out_mem[f] = 16'hDEAD;
    fill_uniform(16'd0, 16'd0);

    // Reset and idle
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_bvm_en", {31'd0, bvm_en}, 32'd0);
    check("reset_dim_en", {31'd0, dim_en}, 32'd0);
    check("reset_dom_en", {31'd0, dom_en}, 32'd0);
    check("reset_finish", {31'd0, finish}, 32'd0);
    repeat (50) tick();
    check("idle_dom_writes", wr_total, 32'd0);
    check("idle_finish", fin_total, 32'd0);
    check("idle_reads", rd_total, 32'd0);

    // 1.0 * 1.0 over 64 elements = 64.0
    fill_uniform(16'h0100, 16'h0100);
    for (int f = 0; f < 8; f++) exp_out[f] = 16'h4000;
    do_run("ones", 1, 0);

    // Positive saturation; go held 3 cycles and re-pulsed mid-READ
    fill_uniform(16'h7FFF, 16'h7FFF);
    for (int f = 0; f < 8; f++) exp_out[f] = 16'h7FFF;
    do_run("sat_go_held", 3, 200);

    // Filter f weights = -f: 0, -64, -128, then negative saturation
    fill_uniform(16'h0100, 16'h0000);
    for (int i = 0; i < 64; i++) begin
      for (int f = 0; f < 8; f++) bvm_mem[8 * i + f] = 16'(-(f * 256));
    end
`ifdef RELU_EN
    for (int f = 0; f < 8; f++) exp_out[f] = 16'h0000;
`else
    exp_out[0] = 16'h0000;
    exp_out[1] = 16'hC000;
    exp_out[2] = 16'h8000;
    for (int f = 3; f < 8; f++) exp_out[f] = 16'h8000;
`endif
    do_run("neg", 1, 0);

    // Reset mid-READ aborts, then a clean run
    fill_uniform(16'h0100, 16'h0100);
    for (int f = 0; f < 8; f++) exp_out[f] = 16'h4000;
    wr0 = wr_total;
    fin0 = fin_total;
    rd0 = rd_total;
    go = 1'b1;
    tick();
    go = 1'b0;
    repeat (100) tick();
    check("abort_reading", {31'd0, bvm_en}, 32'd1);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (600) tick();
    check("abort_dom_writes", wr_total - wr0, 32'd0);
    check("abort_finish", fin_total - fin0, 32'd0);
    check("abort_reads_stopped", {31'd0, ((rd_total - rd0) < 512)}, 32'd1);
    do_run("after_abort", 1, 0);

    check("read_order_errors", seq_err, 32'd0);
    check("tied_write_errors", tie_err, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
